// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
// Publishes each well-framed byte with a one-cycle pulse and keeps a wrapping good-byte count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, watching for a falling start edge
// S_START | half-bit wait, then confirm start bit is still low
// S_DATA  | sample 8 data bits LSB-first, one per bit period
// S_STOP  | one bit period, then check stop bit; publish or flag error
// S_BREAK | stop bit was low; wait for line to return high
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] byte_count
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q,      state_d;
  logic          rx_meta_q,    rx_meta_d;
  logic          rx_s_q,       rx_s_d;
  logic [CW-1:0] bit_cnt_q,    bit_cnt_d;
  logic [2:0]    bit_idx_q,    bit_idx_d;
  logic [7:0]    shift_q,      shift_d;
  logic [7:0]    data_q,       data_d;
  logic          valid_q,      valid_d;
  logic          ferr_q,       ferr_d;
  logic [7:0]    count_q,      count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    count_d   = count_q;

    // bit_cnt is a down-counter reloaded on every state change; zero marks a sample point
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) begin
          state_d   = S_START;
          bit_cnt_d = HALF_LOAD;
        end
      end

      S_START: begin
        if (bit_cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_cnt_d = FULL_LOAD;
            bit_idx_d = '0;
          end else begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end
      end

      S_STOP: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            // leaving at the stop-bit centre lets a back-to-back start edge be caught
            state_d = S_IDLE;
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = 1'b0;
            count_d = count_q + 8'd1;
          end else begin
            state_d = S_BREAK;
            ferr_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end
      end

      S_BREAK: begin
        bit_cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);
  assign byte_count = count_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: drives 8N1 frames at 8 clocks/bit and checks outputs against
// a queue-based model of expected bytes, arrival latency and good-byte counts.
module tb_uart_byte_receiver;

  localparam int CPB     = 8;
  localparam int LAT_MIN = 2 + CPB / 2 + 9 * CPB;
  localparam int LAT_MAX = LAT_MIN + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] byte_count;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  int         pulse_cnt = 0;
  int         sent_good = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] exp_q[$];
  int         fall_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Called at a negedge; a good frame is queued for the monitor with its falling-edge cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      exp_q.push_back(b);
      fall_q.push_back(cyc);
      sent_good++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 1'b0);
  endtask

  // Monitor: every pulse must match the oldest expected byte and arrive within the latency window.
  always @(posedge clk) begin
    int lat;
    #1;
    if (rst) begin
      model_data = 8'h00;
      exp_q.delete();
      fall_q.delete();
    end else begin
      if (data_valid) begin
        pulse_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: data_out 0x%0h with nothing pending (cycle %0d)",
                   data_out, cyc);
        end else begin
          model_data = exp_q.pop_front();
          lat = cyc - fall_q.pop_front();
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
          end
        end
      end
      chk("data_out_hold", data_out, model_data);
    end
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p0;
    int         cnt0;
    int         k;
    logic [7:0] b;
    logic       ok;
    logic [7:0] b77;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out",   data_out,   8'h00);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_frame_err",  frame_err,  1'b0);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_byte_count", byte_count, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single good frame
    p0 = pulse_cnt;
    send_frame(8'hA5, 1'b1);
    wait_idle(4 * CPB, "a5_busy_idle");
    chk("a5_data_out",   data_out,       8'hA5);
    chk("a5_byte_count", byte_count,     8'd1);
    chk("a5_frame_err",  frame_err,      1'b0);
    chk("a5_pulses",     pulse_cnt - p0, 1);

    // two-clock glitch on an idle line
    p0 = pulse_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_busy", busy, 1'b0);
    @(negedge clk);
    chk("glitch_data_out", data_out,       8'hA5);
    chk("glitch_pulses",   pulse_cnt - p0, 0);

    // bad stop bit followed by a long break
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    chk("brk_frame_err",  frame_err,      1'b1);
    chk("brk_busy",       busy,           1'b1);
    chk("brk_data_out",   data_out,       8'hA5);
    chk("brk_byte_count", byte_count,     8'd1);
    chk("brk_pulses",     pulse_cnt - p0, 0);
    rx = 1'b1;
    wait_idle(8, "brk_release_idle");
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("sticky_frame_err", frame_err, 1'b1);
    send_frame(8'h01, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("b01_data_out",   data_out,   8'h01);
    chk("b01_frame_err",  frame_err,  1'b0);
    chk("b01_byte_count", byte_count, 8'd2);

    // random frames, occasional bad stop, random idle gaps
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      rx = 1'b1;
      repeat (CPB * $urandom_range(1, 3)) @(negedge clk);
      chk("rnd_frame_err",  frame_err,  !ok);
      chk("rnd_busy",       busy,       1'b0);
      chk("rnd_byte_count", byte_count, sent_good[7:0]);
    end

    // 256 back-to-back frames with 1-bit stop
    cnt0 = sent_good;
    p0   = pulse_cnt;
    for (int n = 0; n < 256; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
    end
    rx = 1'b1;
    wait_idle(4 * CPB, "b2b_busy_idle");
    repeat (2) @(negedge clk);
    chk("b2b_pulses",     pulse_cnt - p0, 256);
    chk("b2b_byte_count", byte_count,     cnt0[7:0]);
    chk("b2b_frame_err",  frame_err,      1'b0);

    // asynchronous reset during data bit 4 of 0x77
    b77 = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b77[i]);
    rx = b77[4];
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_data_out",   data_out,   8'h00);
    chk("async_rst_data_valid", data_valid, 1'b0);
    chk("async_rst_frame_err",  frame_err,  1'b0);
    chk("async_rst_busy",       busy,       1'b0);
    chk("async_rst_byte_count", byte_count, 8'h00);
    rx = 1'b1;
    sent_good = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    p0 = pulse_cnt;
    send_frame(8'h5A, 1'b1);
    wait_idle(4 * CPB, "b5a_busy_idle");
    chk("b5a_data_out",   data_out,       8'h5A);
    chk("b5a_byte_count", byte_count,     8'd1);
    chk("b5a_pulses",     pulse_cnt - p0, 1);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pending_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
